// File: rtl/sr_cmd_conditioner_pkg.sv
// sr_cmd_conditioner_pkg
//   Shared definitions for the SR command conditioner: arbiter FSM state
//   encodings and default debounce / lockout lengths.
package sr_cmd_conditioner_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  localparam int DEF_DEB_CYCLES = 16;
  localparam int DEF_GAP_CYCLES = 4;

endpackage

// File: rtl/sr_cmd_conditioner_debounce.sv
// sr_cmd_conditioner_debounce
//   One request channel: 2-flop synchroniser, mismatch counter, filtered
//   level and a registered one-cycle pulse on each filtered rising edge.
// Ports
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   i_btn   raw asynchronous button level
//   o_rise  one-cycle pulse when the filtered level goes 0->1
module sr_cmd_conditioner_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        // this cycle is the DEB_CYCLES-th consecutive mismatch
        r_level <= ~r_level;
        r_rise  <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner
//   Turns two bouncing button lines into clean, mutually exclusive,
//   single-cycle set/reset pulses for an SR flip-flop, with a lockout
//   window after every issued command.
// Ports
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_set_btn   raw set request
//   i_clr_btn   raw clear request
//   o_s         one-cycle set pulse
//   o_r         one-cycle reset pulse
//   o_busy      command pending, issuing or in lockout
//   o_conflict  one-cycle pulse when both requests were pending together
module sr_cmd_conditioner
  import sr_cmd_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter bit CLR_PRIORITY = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_set_btn,
  input  logic i_clr_btn,
  output logic o_s,
  output logic o_r,
  output logic o_busy,
  output logic o_conflict
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic          w_set_rise;
  logic          w_clr_rise;
  logic          w_idle;
  logic          w_both;
  logic          w_issue_set;
  logic          w_issue_clr;
  logic          w_issue;
  logic          w_pend_set_nxt;
  logic          w_pend_clr_nxt;
  state_t        w_state_nxt;

  state_t        r_state;
  logic [GW-1:0] r_gap;
  logic          r_pend_set;
  logic          r_pend_clr;
  logic          r_s;
  logic          r_r;
  logic          r_busy;
  logic          r_conflict;

  sr_cmd_conditioner_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_set_btn),
    .o_rise (w_set_rise)
  );

  sr_cmd_conditioner_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_clr_btn),
    .o_rise (w_clr_rise)
  );

  // Arbitration: only from IDLE; on a tie the priority channel wins and
  // the other pending bit is discarded along with it.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_both      = r_pend_set & r_pend_clr;
  assign w_issue_clr = w_idle & r_pend_clr & (~r_pend_set | CLR_PRIORITY);
  assign w_issue_set = w_idle & r_pend_set & ~w_issue_clr;
  assign w_issue     = w_issue_set | w_issue_clr;

  // Any issue clears both bits (winner served, loser dropped); a new rise
  // always lands, including during GAP.
  assign w_pend_set_nxt = w_set_rise | (r_pend_set & ~w_issue);
  assign w_pend_clr_nxt = w_clr_rise | (r_pend_clr & ~w_issue);

  always_comb begin
    w_state_nxt = r_state;
    if (w_issue)
      w_state_nxt = ST_GAP;
    else if (r_state == ST_GAP && r_gap == GW'(1))
      w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_gap      <= '0;
      r_pend_set <= 1'b0;
      r_pend_clr <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_set <= w_pend_set_nxt;
      r_pend_clr <= w_pend_clr_nxt;
      r_s        <= w_issue_set;
      r_r        <= w_issue_clr;
      r_conflict <= w_issue & w_both;
      // busy reflects the state being entered so it lines up with o_s/o_r
      r_busy     <= (w_state_nxt != ST_IDLE) | w_pend_set_nxt | w_pend_clr_nxt;
      if (w_issue)
        r_gap <= GW'(GAP_CYCLES);
      else if (r_state == ST_GAP)
        r_gap <= r_gap - GW'(1);
    end
  end

  assign o_s        = r_s;
  assign o_r        = r_r;
  assign o_busy     = r_busy;
  assign o_conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
module tb_sr_cmd_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_btn = 1'b0;
  logic clr_btn = 1'b0;
  logic s, r, busy, conflict;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sr_cmd_conditioner #(
    .DEB_CYCLES   (4),
    .GAP_CYCLES   (2),
    .CLR_PRIORITY (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_set_btn  (set_btn),
    .i_clr_btn  (clr_btn),
    .o_s        (s),
    .o_r        (r),
    .o_busy     (busy),
    .o_conflict (conflict)
  );

  // Inputs changed right after step() are first sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst = 1'b1; set_btn = 1'b0; clr_btn = 1'b0;
    idle(3);
    exp = 4'b0000;
    checks++;
    if ({s, r, busy, conflict} !== exp) begin
      errors++;
      $display("FAIL reset_hold {s,r,busy,conflict}=%b expected %b", {s, r, busy, conflict}, exp);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if ({s, r, busy, conflict} !== exp) begin
      errors++;
      $display("FAIL reset_release {s,r,busy,conflict}=%b expected %b", {s, r, busy, conflict}, exp);
    end
  endtask

  task automatic test_single_set();
    logic [3:0] exp;
    set_btn = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      exp = {(k == 7), 1'b0, (k >= 6 && k <= 8), 1'b0};
      checks++;
      if ({s, r, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL single_set edge %0d {s,r,busy,conflict}=%b expected %b", k, {s, r, busy, conflict}, exp);
      end
    end
    set_btn = 1'b0;
    idle(15);
  endtask

  task automatic test_bounce();
    logic [3:0] exp;
    for (int i = 0; i < 10; i++) begin
      set_btn = (i % 2 == 0);
      step();
      checks++;
      if ({s, r} !== 2'b00) begin
        errors++;
        $display("FAIL bounce_quiet cycle %0d {s,r}=%b expected 00", i, {s, r});
      end
    end
    set_btn = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      exp = {(k == 7), 1'b0, (k >= 6 && k <= 8), 1'b0};
      checks++;
      if ({s, r, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL bounce_hold edge %0d {s,r,busy,conflict}=%b expected %b", k, {s, r, busy, conflict}, exp);
      end
    end
    set_btn = 1'b0;
    idle(15);
  endtask

  task automatic test_conflict();
    logic [3:0] exp;
    set_btn = 1'b1; clr_btn = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      step();
      exp = {1'b0, (k == 7), (k >= 6 && k <= 8), (k == 7)};
      checks++;
      if ({s, r, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL conflict edge %0d {s,r,busy,conflict}=%b expected %b", k, {s, r, busy, conflict}, exp);
      end
    end
    set_btn = 1'b0; clr_btn = 1'b0;
    idle(15);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    set_btn = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      step();
      if (k == 1) clr_btn = 1'b1;  // clr first sampled at edge 2
      exp = {(k == 7), (k == 10), (k >= 6 && k <= 11), 1'b0};
      checks++;
      if ({s, r, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL back_to_back edge %0d {s,r,busy,conflict}=%b expected %b", k, {s, r, busy, conflict}, exp);
      end
    end
    set_btn = 1'b0; clr_btn = 1'b0;
    idle(15);
  endtask

  task automatic test_mid_reset();
    set_btn = 1'b1;
    for (int k = 0; k <= 6; k++) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pending busy=%b expected 1", busy);
    end
    rst = 1'b1; set_btn = 1'b0;
    step();
    checks++;
    if ({s, r, busy, conflict} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_clear {s,r,busy,conflict}=%b expected 0000", {s, r, busy, conflict});
    end
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      checks++;
      if ({s, r, busy, conflict} !== 4'b0000) begin
        errors++;
        $display("FAIL mid_reset_after cycle %0d {s,r,busy,conflict}=%b expected 0000", k, {s, r, busy, conflict});
      end
    end
  endtask

  task automatic test_hold_through_reset();
    logic [3:0] exp;
    rst = 1'b1; set_btn = 1'b1;
    idle(4);
    checks++;
    if ({s, r, busy, conflict} !== 4'b0000) begin
      errors++;
      $display("FAIL held_in_reset {s,r,busy,conflict}=%b expected 0000", {s, r, busy, conflict});
    end
    rst = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      step();
      exp = {(k == 7), 1'b0, (k >= 6 && k <= 8), 1'b0};
      checks++;
      if ({s, r, busy, conflict} !== exp) begin
        errors++;
        $display("FAIL held_release edge %0d {s,r,busy,conflict}=%b expected %b", k, {s, r, busy, conflict}, exp);
      end
    end
    set_btn = 1'b0;
    idle(15);
  endtask

  task automatic test_random();
    int since = 100;
    int pulses = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(7) == 0) set_btn = ~set_btn;
      if ($urandom_range(7) == 0) clr_btn = ~clr_btn;
      step();
      checks++;
      if ((s & r) !== 1'b0) begin
        errors++;
        $display("FAIL random_exclusive cycle %0d s=%b r=%b expected not both", c, s, r);
      end
      if (s | r) begin
        pulses++;
        checks++;
        if (since < 3) begin
          errors++;
          $display("FAIL random_spacing cycle %0d spacing=%0d expected >=3", c, since);
        end
        since = 1;
      end else begin
        since++;
      end
    end
    checks++;
    if (pulses == 0) begin
      errors++;
      $display("FAIL random_activity pulses=%0d expected >0", pulses);
    end
    set_btn = 1'b0; clr_btn = 1'b0;
    idle(20);
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_bounce();
    test_conflict();
    test_back_to_back();
    test_mid_reset();
    test_hold_through_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
